eth_rx_dispatch: RTL and testbench

//  Sits in the system clock domain downstream of the RX clock-crossing FIFO and schedules each received Ethernet frame to one consumer.

---
 rtl/eth_rx_dispatch.sv | 255 +++++++++++++++++++++++++
 tb/tb_eth_rx_dispatch.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_dispatch.sv
// eth_rx_dispatch: parses the 14-byte MAC header of each received frame,
// filters on destination MAC, and steers the payload to the ARP or IPv4
// consumer by EtherType. It also counts dropped and runt frames.
//
// Handshake rule for every byte port: a beat transfers on a rising edge
// where vld and rdy are both high. A producer holds vld, and its data, until
// rdy is seen. rdy may change freely while vld is low.
module eth_rx_dispatch #(
    parameter logic [47:0] P_MAC_ADDR   = 48'h3A52023E1800,
    parameter logic [15:0] P_ETYPE_ARP  = 16'h0806,
    parameter logic [15:0] P_ETYPE_IPV4 = 16'h0800,
    parameter int          P_CNT_WIDTH  = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_byte_vld,
    output logic                   rx_byte_rdy,
    input  logic                   rx_sof,
    input  logic                   rx_eof,
    output logic [7:0]             arp_byte,
    output logic                   arp_byte_vld,
    input  logic                   arp_byte_rdy,
    output logic                   arp_sof,
    output logic                   arp_eof,
    output logic                   arp_err,
    output logic [7:0]             ip_byte,
    output logic                   ip_byte_vld,
    input  logic                   ip_byte_rdy,
    output logic                   ip_sof,
    output logic                   ip_eof,
    output logic                   ip_err,
    output logic [47:0]            frm_src_mac,
    output logic [15:0]            frm_etype,
    output logic [P_CNT_WIDTH-1:0] drop_cnt,
    output logic [P_CNT_WIDTH-1:0] runt_cnt,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_PAY   = 3'd2,
        S_DROP  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t      state;
    logic [3:0]  hdr_cnt;     // index of the next header byte
    logic        uc_ok;       // destination still matches the station MAC
    logic        bc_ok;       // destination still matches broadcast
    logic [47:0] src_sh;      // source MAC being assembled
    logic [7:0]  etype_hi;    // EtherType high byte
    logic        sel_ip;      // 1: IPv4 port selected, 0: ARP port
    logic        first_pay;   // next payload beat is the first one

    logic        xfer;
    logic        sel_rdy;
    logic        rdy_c;
    logic        o_vld;
    logic        o_sof;
    logic        o_eof;
    logic        o_err;
    logic [7:0]  o_byte;
    logic        hdr_beat;
    logic        hdr_restart;
    logic [3:0]  hdr_idx;
    logic [15:0] etype_w;
    logic        is_arp;
    logic        is_ip;
    logic        dst_ok;
    logic        abort_runt;
    logic        drop_inc;
    logic [1:0]  runt_inc;

    // Station MAC byte for header position idx (0..5), MSB first.
    function automatic logic [7:0] mac_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    mac_byte = P_MAC_ADDR[47:40];
            4'd1:    mac_byte = P_MAC_ADDR[39:32];
            4'd2:    mac_byte = P_MAC_ADDR[31:24];
            4'd3:    mac_byte = P_MAC_ADDR[23:16];
            4'd4:    mac_byte = P_MAC_ADDR[15:8];
            4'd5:    mac_byte = P_MAC_ADDR[7:0];
            default: mac_byte = 8'h00;
        endcase
    endfunction

    // Counter add that sticks at all-ones instead of wrapping.
    function automatic logic [P_CNT_WIDTH-1:0] sat_add(input logic [P_CNT_WIDTH-1:0] cnt,
                                                       input logic [1:0] inc);
        logic [P_CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {{(P_CNT_WIDTH-1){1'b0}}, inc};
        if (sum[P_CNT_WIDTH])
            sat_add = '1;
        else
            sat_add = sum[P_CNT_WIDTH-1:0];
    endfunction

    assign sel_rdy   = sel_ip ? ip_byte_rdy : arp_byte_rdy;
    assign xfer      = rx_byte_vld & rx_byte_rdy;
    assign dbg_state = state;

    // Input ready and the selected-port beat, derived from the current state.
    always_comb begin
        rdy_c  = 1'b0;
        o_vld  = 1'b0;
        o_byte = 8'h00;
        o_sof  = 1'b0;
        o_eof  = 1'b0;
        o_err  = 1'b0;
        case (state)
            S_IDLE, S_HDR, S_DROP: rdy_c = 1'b1;
            S_PAY: begin
                // A new frame start is held back at the input and becomes an abort.
                o_vld  = rx_byte_vld & ~rx_sof;
                o_byte = rx_byte;
                o_sof  = first_pay & o_vld;
                o_eof  = rx_eof & o_vld;
                rdy_c  = sel_rdy & ~rx_sof;
            end
            S_ABORT: begin
                o_vld = 1'b1;
                o_sof = first_pay;
                o_eof = 1'b1;
                o_err = 1'b1;
            end
            default: ;
        endcase
        rx_byte_rdy = rdy_c & ~sys_rst;
    end

    // The beat goes to the selected port only; the other port stays idle.
    always_comb begin
        arp_byte_vld = o_vld & ~sel_ip;
        arp_byte     = sel_ip ? 8'h00 : o_byte;
        arp_sof      = o_sof & ~sel_ip;
        arp_eof      = o_eof & ~sel_ip;
        arp_err      = o_err & ~sel_ip;
        ip_byte_vld  = o_vld & sel_ip;
        ip_byte      = sel_ip ? o_byte : 8'h00;
        ip_sof       = o_sof & sel_ip;
        ip_eof       = o_eof & sel_ip;
        ip_err       = o_err & sel_ip;
    end

    // Header beat decode: which header position this beat occupies, and the events it raises.
    always_comb begin
        hdr_beat    = 1'b0;
        hdr_restart = 1'b0;
        hdr_idx     = hdr_cnt;
        case (state)
            S_IDLE, S_DROP: begin
                hdr_beat = xfer & rx_sof;
                hdr_idx  = 4'd0;
            end
            S_HDR: begin
                hdr_beat = xfer;
                if (rx_sof) begin
                    hdr_idx     = 4'd0;
                    // After an abort the header restarts at position 0, which is not a runt.
                    hdr_restart = xfer & (hdr_cnt != 4'd0);
                end
            end
            default: ;
        endcase
        etype_w    = {etype_hi, rx_byte};
        is_arp     = (etype_w == P_ETYPE_ARP);
        is_ip      = (etype_w == P_ETYPE_IPV4);
        dst_ok     = uc_ok | bc_ok;
        abort_runt = (state == S_PAY) & rx_byte_vld & rx_sof & first_pay;
        drop_inc   = hdr_beat & (hdr_idx == 4'd13) & ~rx_eof & ~(dst_ok & (is_arp | is_ip));
        runt_inc   = {1'b0, hdr_restart} + {1'b0, hdr_beat & rx_eof} + {1'b0, abort_runt};
    end

    // Frame-level FSM: header parsing, routing decision, payload and abort tracking.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            hdr_cnt     <= 4'd0;
            uc_ok       <= 1'b1;
            bc_ok       <= 1'b1;
            src_sh      <= 48'h0;
            etype_hi    <= 8'h00;
            sel_ip      <= 1'b0;
            first_pay   <= 1'b0;
            frm_src_mac <= 48'h0;
            frm_etype   <= 16'h0;
        end else if (hdr_beat) begin
            hdr_cnt <= hdr_idx + 4'd1;
            if (hdr_idx == 4'd0) begin
                uc_ok <= (rx_byte == mac_byte(4'd0));
                bc_ok <= (rx_byte == 8'hFF);
            end else if (hdr_idx < 4'd6) begin
                uc_ok <= uc_ok & (rx_byte == mac_byte(hdr_idx));
                bc_ok <= bc_ok & (rx_byte == 8'hFF);
            end
            if ((hdr_idx >= 4'd6) && (hdr_idx < 4'd12))
                src_sh <= {src_sh[39:0], rx_byte};
            if (hdr_idx == 4'd12)
                etype_hi <= rx_byte;
            if (rx_eof) begin
                state <= S_IDLE;
            end else if (hdr_idx == 4'd13) begin
                if (dst_ok & (is_arp | is_ip)) begin
                    state       <= S_PAY;
                    sel_ip      <= is_ip;
                    first_pay   <= 1'b1;
                    frm_src_mac <= src_sh;
                    frm_etype   <= etype_w;
                end else begin
                    state <= S_DROP;
                end
            end else begin
                state <= S_HDR;
            end
        end else begin
            case (state)
                S_PAY: begin
                    if (rx_byte_vld & rx_sof) begin
                        state <= S_ABORT;
                    end else if (xfer) begin
                        first_pay <= 1'b0;
                        if (rx_eof)
                            state <= S_IDLE;
                    end
                end
                S_ABORT: begin
                    if (sel_rdy) begin
                        state     <= S_HDR;
                        hdr_cnt   <= 4'd0;
                        first_pay <= 1'b0;
                    end
                end
                S_DROP: begin
                    if (xfer & rx_eof)
                        state <= S_IDLE;
                end
                default: ;
            endcase
        end
    end

    // Saturating drop and runt counters.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            drop_cnt <= '0;
            runt_cnt <= '0;
        end else begin
            drop_cnt <= sat_add(drop_cnt, {1'b0, drop_inc});
            runt_cnt <= sat_add(runt_cnt, runt_inc);
        end
    end

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Bench for eth_rx_dispatch: directed frames, a frame-level reference model
// feeding per-port expected queues, and a per-cycle output compare process.
module tb_eth_rx_dispatch;

    localparam logic [47:0] MAC  = 48'h3A52023E1800;
    localparam logic [47:0] BC   = 48'hFFFFFFFFFFFF;
    localparam logic [15:0] ARP  = 16'h0806;
    localparam logic [15:0] IPV4 = 16'h0800;

    // ---------------- clock / reset ----------------
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    logic [7:0]  rx_byte = 8'h00;
    logic        rx_byte_vld = 1'b0;
    logic        rx_sof = 1'b0;
    logic        rx_eof = 1'b0;
    logic        arp_byte_rdy = 1'b1;
    logic        ip_byte_rdy = 1'b1;
    logic        tog_ip = 1'b0;
    logic        chk_mirror = 1'b0;

    logic        rx_byte_rdy;
    logic [7:0]  arp_byte, ip_byte;
    logic        arp_byte_vld, arp_sof, arp_eof, arp_err;
    logic        ip_byte_vld, ip_sof, ip_eof, ip_err;
    logic [47:0] frm_src_mac;
    logic [15:0] frm_etype;
    logic [15:0] drop_cnt, runt_cnt;
    logic [2:0]  dbg_state;

    logic        n_rdy;
    logic [7:0]  n_arp_byte, n_ip_byte;
    logic        n_arp_vld, n_arp_sof, n_arp_eof, n_arp_err;
    logic        n_ip_vld, n_ip_sof, n_ip_eof, n_ip_err;
    logic [47:0] n_src;
    logic [15:0] n_et;
    logic [1:0]  n_drop, n_runt;
    logic [2:0]  n_state;

    eth_rx_dispatch u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .rx_byte(rx_byte), .rx_byte_vld(rx_byte_vld), .rx_byte_rdy(rx_byte_rdy),
        .rx_sof(rx_sof), .rx_eof(rx_eof),
        .arp_byte(arp_byte), .arp_byte_vld(arp_byte_vld), .arp_byte_rdy(arp_byte_rdy),
        .arp_sof(arp_sof), .arp_eof(arp_eof), .arp_err(arp_err),
        .ip_byte(ip_byte), .ip_byte_vld(ip_byte_vld), .ip_byte_rdy(ip_byte_rdy),
        .ip_sof(ip_sof), .ip_eof(ip_eof), .ip_err(ip_err),
        .frm_src_mac(frm_src_mac), .frm_etype(frm_etype),
        .drop_cnt(drop_cnt), .runt_cnt(runt_cnt), .dbg_state(dbg_state)
    );

    // Narrow-counter instance on the same stream, used for saturation.
    eth_rx_dispatch #(.P_CNT_WIDTH(2)) u_dut_n (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .rx_byte(rx_byte), .rx_byte_vld(rx_byte_vld), .rx_byte_rdy(n_rdy),
        .rx_sof(rx_sof), .rx_eof(rx_eof),
        .arp_byte(n_arp_byte), .arp_byte_vld(n_arp_vld), .arp_byte_rdy(arp_byte_rdy),
        .arp_sof(n_arp_sof), .arp_eof(n_arp_eof), .arp_err(n_arp_err),
        .ip_byte(n_ip_byte), .ip_byte_vld(n_ip_vld), .ip_byte_rdy(ip_byte_rdy),
        .ip_sof(n_ip_sof), .ip_eof(n_ip_eof), .ip_err(n_ip_err),
        .frm_src_mac(n_src), .frm_etype(n_et),
        .drop_cnt(n_drop), .runt_cnt(n_runt), .dbg_state(n_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    // beat = {byte, sof, eof, err}
    logic [10:0] exp_arp_q[$];
    logic [10:0] exp_ip_q[$];
    logic [47:0] exp_src = '0;
    logic [15:0] exp_et = '0;
    int exp_drop = 0;
    int exp_runt = 0;
    int xfer_cnt[2] = '{0, 0};
    logic        hold_prev[2] = '{1'b0, 1'b0};
    logic [10:0] prev_beat[2];
    logic [10:0] last_beat[2];

    logic [7:0] frm[0:127];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One port's beat against the expected queue, plus vld hold stability.
    task automatic check_port(input int p, input logic vld, input logic rdy, input logic [10:0] beat);
        string nm;
        logic [10:0] e;
        int qs;
        nm = (p == 1) ? "ip" : "arp";
        qs = (p == 1) ? exp_ip_q.size() : exp_arp_q.size();
        if (hold_prev[p])
            chk({nm, "_hold"}, {53'h0, vld, beat}, {53'h0, 1'b1, prev_beat[p]});
        if (vld && qs == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected: got beat %0h expected no beat", nm, beat);
        end else if (vld && rdy) begin
            e = (p == 1) ? exp_ip_q.pop_front() : exp_arp_q.pop_front();
            chk({nm, "_beat"}, beat, e);
            if (!e[0]) begin
                chk({nm, "_src_mac"}, frm_src_mac, exp_src);
                chk({nm, "_etype"}, frm_etype, exp_et);
            end
            xfer_cnt[p]++;
            last_beat[p] = beat;
        end
        hold_prev[p] = vld && !rdy;
        prev_beat[p] = beat;
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            check_port(0, arp_byte_vld, arp_byte_rdy, {arp_byte, arp_sof, arp_eof, arp_err});
            check_port(1, ip_byte_vld, ip_byte_rdy, {ip_byte, ip_sof, ip_eof, ip_err});
            if (chk_mirror && rx_byte_vld)
                chk("rdy_mirror", rx_byte_rdy, ip_byte_rdy);
        end
    end

    // ---------------- reference model ----------------
    // Frame-level rules: no payload -> runt; bad dst or EtherType -> drop;
    // otherwise payload beats (or a truncated run plus an error beat) go to one port.
    task automatic model_frame(input int len, input int abort_after);
        logic [47:0] dst, src;
        logic [15:0] et;
        int n;
        logic [10:0] b;
        if (len <= 14) begin
            exp_runt++;
        end else begin
            for (int i = 0; i < 6; i++) begin
                dst[47-8*i -: 8] = frm[i];
                src[47-8*i -: 8] = frm[6+i];
            end
            et = {frm[12], frm[13]};
            if (!((dst == MAC || dst == BC) && (et == ARP || et == IPV4))) begin
                exp_drop++;
            end else begin
                exp_src = src;
                exp_et  = et;
                n = (abort_after < 0) ? len - 14 : abort_after;
                for (int j = 0; j < n; j++) begin
                    b = {frm[14+j], j == 0, (abort_after < 0) && (j == n - 1), 1'b0};
                    if (et == IPV4) exp_ip_q.push_back(b); else exp_arp_q.push_back(b);
                end
                if (abort_after >= 0) begin
                    b = {8'h00, n == 0, 1'b1, 1'b1};
                    if (n == 0) exp_runt++;
                    if (et == IPV4) exp_ip_q.push_back(b); else exp_arp_q.push_back(b);
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sof, input logic eof);
        logic got;
        int cyc;
        rx_byte = b;
        rx_sof = sof;
        rx_eof = eof;
        rx_byte_vld = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 300) begin
            @(negedge sys_clk);
            got = rx_byte_rdy;
            @(posedge sys_clk);
            #1;
            cyc++;
        end
        if (!got) chk("rx_timeout", 64'd0, 64'd1);
        rx_byte_vld = 1'b0;
        rx_sof = 1'b0;
        rx_eof = 1'b0;
    endtask

    task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                         input int plen, input logic [7:0] seed);
        for (int i = 0; i < 6; i++) begin
            frm[i]   = dst[47-8*i -: 8];
            frm[6+i] = src[47-8*i -: 8];
        end
        frm[12] = et[15:8];
        frm[13] = et[7:0];
        for (int i = 0; i < plen; i++) frm[14+i] = seed + 8'(i);
    endtask

    task automatic send_frame(input int len, input int abort_after, input bit mirror);
        model_frame(len, abort_after);
        for (int i = 0; i < len; i++) begin
            if (abort_after >= 0 && i == 14 + abort_after) break;
            chk_mirror = mirror && (i >= 14);
            send_byte(frm[i], i == 0, i == len - 1);
        end
        chk_mirror = 1'b0;
    endtask

    task automatic check_counters();
        idle(2);
        chk("drop_cnt", drop_cnt, exp_drop);
        chk("runt_cnt", runt_cnt, exp_runt);
        chk("drop_cnt_w2", n_drop, (exp_drop > 3) ? 3 : exp_drop);
        chk("runt_cnt_w2", n_runt, (exp_runt > 3) ? 3 : exp_runt);
    endtask

    // ---------------- directed sequence ----------------
    int a0, i0;
    initial begin
        // Reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_rdy", rx_byte_rdy, 1'b0);
        chk("rst_arp_vld", arp_byte_vld, 1'b0);
        chk("rst_ip_vld", ip_byte_vld, 1'b0);
        chk("rst_src", frm_src_mac, 48'h0);
        chk("rst_etype", frm_etype, 16'h0);
        chk("rst_drop", drop_cnt, 16'h0);
        chk("rst_runt", runt_cnt, 16'h0);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("idle_state", dbg_state, 3'd0);
        chk("idle_rdy", rx_byte_rdy, 1'b1);
        idle(1);

        // 1: ARP broadcast, 28-byte payload, ip not ready
        ip_byte_rdy = 1'b0;
        arp_byte_rdy = 1'b1;
        build(BC, 48'h001122334455, ARP, 28, 8'h10);
        send_frame(42, -1, 1'b0);
        check_counters();
        chk("t1_arp_beats", xfer_cnt[0], 28);
        chk("t1_ip_beats", xfer_cnt[1], 0);
        chk("t1_etype_lit", frm_etype, 16'h0806);
        chk("t1_src_lit", frm_src_mac, 48'h001122334455);
        chk("t1_last_lit", last_beat[0], {8'h2B, 1'b0, 1'b1, 1'b0});

        // 2: IPv4 unicast, 46-byte payload, ip_rdy toggling
        ip_byte_rdy = 1'b1;
        tog_ip = 1'b1;
        i0 = xfer_cnt[1];
        build(MAC, 48'hA0B1C2D3E4F5, IPV4, 46, 8'hC0);
        send_frame(60, -1, 1'b1);
        tog_ip = 1'b0;
        ip_byte_rdy = 1'b1;
        check_counters();
        chk("t2_ip_beats", xfer_cnt[1] - i0, 46);

        // 3: wrong destination, then unknown EtherType
        a0 = xfer_cnt[0];
        i0 = xfer_cnt[1];
        build(48'h020000000001, 48'h111111111111, IPV4, 46, 8'h00);
        send_frame(60, -1, 1'b0);
        check_counters();
        chk("t3_drop1_lit", drop_cnt, 16'd1);
        build(MAC, 48'h111111111111, 16'h86DD, 46, 8'h00);
        send_frame(60, -1, 1'b0);
        check_counters();
        chk("t3_drop2_lit", drop_cnt, 16'd2);
        chk("t3_no_beats", (xfer_cnt[0] - a0) + (xfer_cnt[1] - i0), 0);

        // 4: 10-byte runt, header-only runt, then a stray non-sof byte in IDLE
        build(MAC, 48'h222222222222, IPV4, 0, 8'h00);
        send_frame(10, -1, 1'b0);
        send_frame(14, -1, 1'b0);
        send_byte(8'hAA, 1'b0, 1'b1);
        check_counters();
        chk("t4_runt_lit", runt_cnt, 16'd2);
        chk("t4_state_idle", dbg_state, 3'd0);
        chk("t4_no_beats", (xfer_cnt[0] - a0) + (xfer_cnt[1] - i0), 0);

        // 5: sof after 5 IPv4 payload bytes, then a full ARP frame
        i0 = xfer_cnt[1];
        a0 = xfer_cnt[0];
        build(MAC, 48'h333333333333, IPV4, 20, 8'h50);
        send_frame(34, 5, 1'b0);
        build(BC, 48'h444444444444, ARP, 28, 8'h70);
        send_frame(42, -1, 1'b0);
        check_counters();
        chk("t5_ip_beats", xfer_cnt[1] - i0, 6);
        chk("t5_abort_lit", last_beat[1], 11'h003);
        chk("t5_arp_beats", xfer_cnt[0] - a0, 28);
        chk("t5_src_lit", frm_src_mac, 48'h444444444444);

        // 6: five more dropped frames; narrow counter saturates
        build(48'h3A52023E1801, 48'h5, IPV4, 4, 8'h00);  send_frame(18, -1, 1'b0);
        build(48'hFFFFFFFFFFFE, 48'h5, ARP, 4, 8'h00);   send_frame(18, -1, 1'b0);
        build(MAC, 48'h5, 16'h1234, 4, 8'h00);           send_frame(18, -1, 1'b0);
        build(BC, 48'h5, 16'h86DD, 4, 8'h00);            send_frame(18, -1, 1'b0);
        build(48'h0, 48'h5, IPV4, 4, 8'h00);             send_frame(18, -1, 1'b0);
        check_counters();
        chk("t6_drop_w2_lit", n_drop, 2'd3);
        chk("t6_drop_lit", drop_cnt, 16'd7);

        idle(4);
        chk("arp_q_empty", exp_arp_q.size(), 0);
        chk("ip_q_empty", exp_ip_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Consumer ready toggler for the IPv4 port.
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (tog_ip) ip_byte_rdy = ~ip_byte_rdy;
        end
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
